// File: rtl/dram_controller.sv
// Single-bank FPM DRAM controller for the 68030 board: row/column multiplexing,
// byte-lane CAS, 32-bit DSACK termination and autonomous CAS-before-RAS refresh.
module dram_controller #(
    parameter int T_RCD          = 2,
    parameter int T_CAS          = 2,
    parameter int T_RP           = 2,
    parameter int T_RAS_REF      = 3,
    parameter int REFRESH_CYCLES = 390
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CS_DRAM_n,
    input  logic        AS_n,
    input  logic        DS_n,
    input  logic        RW,
    input  logic        SIZ0,
    input  logic        SIZ1,
    input  logic [23:0] A,
    output logic [10:0] MA,
    output logic        RAS_n,
    output logic [3:0]  CAS_n,
    output logic        WE_n,
    output logic        DSACK0_DRAM_n,
    output logic        DSACK1_DRAM_n,
    output logic        REF_ACTIVE
);

    localparam int               REF_W    = $clog2(REFRESH_CYCLES + 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [3:0]       RCD_LAST = 4'(T_RCD - 1);
    localparam logic [3:0]       CAS_LAST = 4'(T_CAS - 1);
    localparam logic [3:0]       RP_LAST  = 4'(T_RP - 1);
    localparam logic [3:0]       RAS_LAST = 4'(T_RAS_REF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW,
        S_COL,
        S_CASW,
        S_ACK,
        S_PRE,
        S_REF_CAS,
        S_REF_RAS
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic               ref_pend_q, ref_pend_d;
    logic               ref_act_q, ref_act_d;
    logic [10:0]        col_q, col_d;
    logic [1:0]         a_lo_q, a_lo_d;
    logic [1:0]         siz_q, siz_d;
    logic               rw_q, rw_d;
    logic [10:0]        ma_q, ma_d;
    logic               ras_n_q, ras_n_d;
    logic [3:0]         cas_n_q, cas_n_d;
    logic               we_n_q, we_n_d;
    logic               dsack_n_q, dsack_n_d;

    logic               ref_tc;
    logic               start;
    logic               abort;
    logic               to_pre;
    logic [2:0]         nbytes;
    logic [3:0]         lane_mask;

    // Active-low CAS mask: byte offset k drives CAS_n[3-k]; lanes past offset 3 are dropped.
    always_comb begin
        lane_mask = 4'hF;
        nbytes    = (siz_q == 2'b00) ? 3'd4 : {1'b0, siz_q};
        for (int k = 0; k < 4; k++) begin
            if ((3'(k) >= {1'b0, a_lo_q}) && (3'(k) < ({1'b0, a_lo_q} + nbytes))) begin
                lane_mask[3 - k] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ref_act_d  = ref_act_q;
        col_d      = col_q;
        a_lo_d     = a_lo_q;
        siz_d      = siz_q;
        rw_d       = rw_q;
        ma_d       = ma_q;
        ras_n_d    = ras_n_q;
        cas_n_d    = cas_n_q;
        we_n_d     = we_n_q;
        dsack_n_d  = dsack_n_q;
        to_pre     = 1'b0;
        start      = ~CS_DRAM_n & ~AS_n;
        abort      = AS_n | CS_DRAM_n;
        ref_tc     = (ref_cnt_q == REF_LAST);
        ref_cnt_d  = ref_tc ? '0 : ref_cnt_q + REF_W'(1);
        ref_pend_d = ref_pend_q | ref_tc;

        case (state_q)
            S_IDLE: begin
                // A request raised on this very edge still wins over a new access.
                if (ref_pend_q || ref_tc) begin
                    state_d    = S_REF_CAS;
                    ref_pend_d = 1'b0;
                    ref_act_d  = 1'b1;
                    cas_n_d    = 4'h0;
                    ras_n_d    = 1'b1;
                    we_n_d     = 1'b1;
                end else if (start) begin
                    state_d = S_ROW;
                    cnt_d   = '0;
                    col_d   = A[12:2];
                    a_lo_d  = A[1:0];
                    siz_d   = {SIZ1, SIZ0};
                    rw_d    = RW;
                    ma_d    = A[23:13];
                    ras_n_d = 1'b0;
                end
            end
            S_ROW: begin
                if (abort) begin
                    to_pre = 1'b1;
                end else if (cnt_q == RCD_LAST) begin
                    state_d = S_COL;
                    ma_d    = col_q;
                    we_n_d  = rw_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_COL: begin
                if (abort) begin
                    to_pre = 1'b1;
                end else begin
                    state_d = S_CASW;
                    cnt_d   = '0;
                    if (rw_q) begin
                        cas_n_d = 4'h0;
                    end else if (!DS_n) begin
                        cas_n_d = lane_mask;
                    end
                end
            end
            S_CASW: begin
                // All-ones CAS here means a write still waiting for its data strobe.
                if (abort) begin
                    to_pre = 1'b1;
                end else if (cas_n_q == 4'hF) begin
                    if (!DS_n) begin
                        cas_n_d = lane_mask;
                    end
                end else if (cnt_q == CAS_LAST) begin
                    state_d   = S_ACK;
                    dsack_n_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ACK: begin
                if (AS_n) begin
                    to_pre = 1'b1;
                end
            end
            S_PRE: begin
                if (cnt_q == RP_LAST) begin
                    state_d   = S_IDLE;
                    ref_act_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_REF_CAS: begin
                state_d = S_REF_RAS;
                cnt_d   = '0;
                ras_n_d = 1'b0;
            end
            S_REF_RAS: begin
                if (cnt_q == RAS_LAST) begin
                    to_pre = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                to_pre = 1'b1;
            end
        endcase

        if (to_pre) begin
            state_d   = S_PRE;
            cnt_d     = '0;
            ras_n_d   = 1'b1;
            cas_n_d   = 4'hF;
            we_n_d    = 1'b1;
            dsack_n_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
            ref_act_q  <= 1'b0;
            col_q      <= '0;
            a_lo_q     <= '0;
            siz_q      <= '0;
            rw_q       <= 1'b1;
            ma_q       <= '0;
            ras_n_q    <= 1'b1;
            cas_n_q    <= 4'hF;
            we_n_q     <= 1'b1;
            dsack_n_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
            ref_act_q  <= ref_act_d;
            col_q      <= col_d;
            a_lo_q     <= a_lo_d;
            siz_q      <= siz_d;
            rw_q       <= rw_d;
            ma_q       <= ma_d;
            ras_n_q    <= ras_n_d;
            cas_n_q    <= cas_n_d;
            we_n_q     <= we_n_d;
            dsack_n_q  <= dsack_n_d;
        end
    end

    assign MA            = ma_q;
    assign RAS_n         = ras_n_q;
    assign CAS_n         = cas_n_q;
    assign WE_n          = we_n_q;
    assign DSACK0_DRAM_n = dsack_n_q;
    assign DSACK1_DRAM_n = dsack_n_q;
    assign REF_ACTIVE    = ref_act_q;

endmodule

// File: doc/dram_controller.md
Name: dram_controller

Overview:
- Single-bank FPM DRAM controller for the 68030 board.
- Consumes the system controller's DRAM chip select and the raw bus strobes. Drives multiplexed row/column address, RAS/CAS/WE, and the DSACK pair that the system controller forwards as DSACK0_DRAM_n/DSACK1_DRAM_n.
- Acts as a 32-bit port, so both DSACKs are asserted together.
- Runs periodic CAS-before-RAS refresh autonomously.

Parameters:
- T_RCD, 2: clocks from RAS_n fall to MA switching to column.
- T_CAS, 2: clocks CAS_n held low before DSACK asserts.
- T_RP, 2: clocks of RAS/CAS precharge after every access or refresh.
- T_RAS_REF, 3: clocks RAS_n held low during refresh.
- REFRESH_CYCLES, 390: clock period of the refresh request (7.8 us at 50 MHz).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- CS_DRAM_n  in  1  DRAM select from the system controller (active-low).
- AS_n  in  1  CPU address strobe.
- DS_n  in  1  CPU data strobe.
- RW  in  1  1 = read, 0 = write.
- SIZ0  in  1  transfer size bit 0.
- SIZ1  in  1  transfer size bit 1.
- A  in  24  CPU address A[23:0].
- MA  out  11  multiplexed DRAM address.
- RAS_n  out  1  row strobe.
- CAS_n  out  4  column strobes. CAS_n[3] = D31:24 (byte offset 0) … CAS_n[0] = D7:0 (offset 3).
- WE_n  out  1  DRAM write enable.
- DSACK0_DRAM_n  out  1  data/size acknowledge 0.
- DSACK1_DRAM_n  out  1  data/size acknowledge 1.
- REF_ACTIVE  out  1  high while a refresh sequence is in progress (debug).

Behaviour:
- Outputs are registered. While RST is high, or on the first edge after it:
  - state IDLE;
  - RAS_n=1, CAS_n=4'hF, WE_n=1, MA=0;
  - both DSACK=1, REF_ACTIVE=0;
  - refresh counter=0, refresh_pending=0.
- Reset mid-cycle aborts immediately to these values.
- Address split: column = A[12:2], row = A[23:13].
- Start condition = ~CS_DRAM_n & ~AS_n, sampled in IDLE. On start, latch row, column, A[1:0], SIZ and RW.
- Refresh counter:
  - Free-running 0..REFRESH_CYCLES-1, then wraps.
  - Reaching terminal count sets refresh_pending.
  - Entering REF_CAS clears refresh_pending.
  - Pending saturates: no more than one outstanding request.
- IDLE priority: refresh_pending beats start when both hold on the same edge. The access then waits, with DSACK held high, and is served after refresh precharge if AS_n is still low.
- ROW state:
  - Entered on the start edge with MA=row and RAS_n=0.
  - After T_RCD clocks, go to COL.
- COL state:
  - MA=column.
  - WE_n=0 if the cycle is a write.
  - One clock later, go to CASW.
- CASW state:
  - Reads: CAS_n=4'h0.
  - Writes: wait for DS_n=0, then CAS_n = lane mask.
  - Lane mask covers byte offsets from A[1:0] for N bytes (SIZ 01=1, 10=2, 11=3, 00=4), truncated at offset 3. Examples: long at offset 2 → lanes 2,3; word at offset 3 → lane 3 only.
  - After T_CAS clocks with CAS low, go to ACK.
- ACK state:
  - DSACK0_DRAM_n = DSACK1_DRAM_n = 0.
  - RAS, CAS and WE are held.
  - On the first edge with AS_n=1: deassert all strobes and both DSACKs, then go to PRE.
- PRE state: RAS_n=1, CAS_n=4'hF for T_RP clocks, then IDLE.
- Refresh sequence:
  - REF_CAS: CAS_n=4'h0 for 1 clock, RAS_n=1, WE_n=1.
  - REF_RAS: RAS_n=0 for T_RAS_REF clocks.
  - Then PRE.
  - REF_ACTIVE is high from REF_CAS through the end of PRE.
- Abort: AS_n=1 (or CS_DRAM_n=1) in ROW, COL or CASW → go straight to PRE; DSACK is never asserted.
- Read latency (defaults): RAS at start edge; MA=column at +2; CAS at +3; DSACK at +5.
- Writes add however many clocks DS_n stays high.

Test Plan:
- Reset: hold RST for 3 clocks mid-cycle → next edge RAS_n=1, CAS_n=4'hF, WE_n=1, both DSACK=1, MA=0.
- Long read at 0x123456:
  - MA=0x091 with RAS_n low at edge 0;
  - MA=0x515 at edge 2;
  - CAS_n=0000 at edge 3;
  - both DSACK low at edge 5;
  - AS_n high → all strobes high next edge, then 2 precharge clocks.
- Byte write at offset 3 with DS_n delayed 2 clocks:
  - WE_n low in COL;
  - CAS_n=4'b1110 only after DS_n falls;
  - DSACK 2 clocks later.
- Word write at offset 1 → CAS_n=4'b1001. Long write at offset 2 → CAS_n=4'b1100.
- Refresh/start collision (REFRESH_CYCLES=16): start on the edge pending is set → refresh first:
  - CAS_n=0 with RAS_n=1;
  - then RAS_n low 3 clocks;
  - REF_ACTIVE high;
  - then the access completes normally.
- AS_n abort in CASW → strobes high next edge, DSACK never asserted, IDLE after T_RP.
